// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
// Owns the fetch PC, issues one outstanding req/ack fetch at a time to a
// variable-latency instruction memory, buffers up to DEPTH fetched
// instructions, and flushes/refetches on redirect.
// Optional build macro FETCH_BYPASS_EN: an ack landing on an empty queue
// is presented to the consumer combinationally in the same cycle.
module fetch_queue #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0,
    parameter int PC_INC   = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_npc,
    input  logic              inst_ready,
    output logic              err
);

    // Out-of-range DEPTH still elaborates; it just raises err out of reset.
    localparam bit DEPTH_BAD = (DEPTH < 2) || (DEPTH > 16);
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] INC     = ADDR_W'(PC_INC);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST    = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_nx;
    logic              take, push, pop, space;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // An ack in REQ without a redirect delivers a keeper; DRAIN acks are dropped.
    assign take = (state == REQ) && imem_ack && !redirect;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass = take && (count == '0);
    assign push   = take && !(bypass && inst_ready);
`else
    assign push   = take;
`endif

    // A redirect flushes the queue, so any pop in that cycle is moot.
    assign pop = !redirect && inst_ready && (count != '0);

    // Occupancy after this edge, used for the issue-space decision.
    always_comb begin
        if (redirect)
            count_nx = '0;
        else
            count_nx = count + CNT_W'(push) - CNT_W'(pop);
        space = (count_nx < DEPTH_C);
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nx;
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Entry storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{inst: imem_rdata, pc: imem_addr};
    end

    // Fetch FSM: one request outstanding at most, registered req/addr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RST_PC;
            imem_req  <= 1'b0;
            imem_addr <= RST_PC;
            err       <= DEPTH_BAD;
        end else begin
            if (imem_ack && state == IDLE) err <= 1'b1;
            case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                    end else if (!halt && space) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        if (imem_ack) begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        fetch_pc <= fetch_pc + INC;
                        if (!halt && space) begin
                            imem_addr <= fetch_pc + INC;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (redirect) fetch_pc <= redirect_pc;
                    if (imem_ack) begin
                        if (!redirect && !halt && space) begin
                            state     <= REQ;
                            imem_addr <= fetch_pc;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Head-of-queue presentation; all zero when nothing is valid.
    always_comb begin
        inst_valid = 1'b0;
        inst       = '0;
        inst_pc    = '0;
        if (count != '0) begin
            inst_valid = 1'b1;
            inst       = mem[rd_ptr].inst;
            inst_pc    = mem[rd_ptr].pc;
        end
`ifdef FETCH_BYPASS_EN
        else if (bypass) begin
            inst_valid = 1'b1;
            inst       = imem_rdata;
            inst_pc    = imem_addr;
        end
`endif
        inst_npc = inst_valid ? inst_pc + INC : '0;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus a randomized run, checked every
// cycle against a queue-based behavioural model of the fetch front end.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        halt = 1'b0;
    logic        inst_valid;
    logic [15:0] inst, inst_pc, inst_npc;
    logic        inst_ready = 1'b0;
    logic        err;

    always #5 clk = ~clk;

    fetch_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .RESET_PC(0), .PC_INC(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_npc(inst_npc),
        .inst_ready(inst_ready), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] q_inst[$];
    logic [15:0] q_pc[$];
    bit          m_out, m_drop, m_err, m_done, m_got, m_pop;
    logic [15:0] m_addr = 16'h0;
    logic [15:0] m_fpc  = 16'h0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_inst.delete(); q_pc.delete();
            m_out = 0; m_drop = 0; m_err = 0;
            m_addr = 16'h0; m_fpc = 16'h0;
        end else begin
            if (imem_ack && !m_out) m_err = 1;
            m_done = imem_ack && m_out;
            m_got  = m_done && !m_drop && !redirect;
            m_pop  = inst_ready && (q_pc.size() > 0) && !redirect;
            if (redirect) begin
                q_inst.delete(); q_pc.delete();
                m_fpc = redirect_pc;
            end else begin
                if (m_pop) begin void'(q_inst.pop_front()); void'(q_pc.pop_front()); end
                if (m_got) begin
                    q_inst.push_back(imem_rdata);
                    q_pc.push_back(m_addr);
                    m_fpc = m_addr + 16'd2;
                end
            end
            if (m_out && !m_done) begin
                if (redirect) m_drop = 1;
            end else begin
                m_out = 0;
                if (!halt && !redirect && q_pc.size() < DEPTH) begin
                    m_out = 1; m_drop = 0; m_addr = m_fpc;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("imem_req", imem_req, m_out);
            if (m_out) chk("imem_addr", imem_addr, m_addr);
            chk("inst_valid", inst_valid, q_pc.size() != 0);
            chk("inst", inst, (q_inst.size() != 0) ? q_inst[0] : 16'h0);
            chk("inst_pc", inst_pc, (q_pc.size() != 0) ? q_pc[0] : 16'h0);
            chk("inst_npc", inst_npc, (q_pc.size() != 0) ? 16'(q_pc[0] + 16'd2) : 16'h0);
            chk("err", err, m_err);
        end
    end

    // ---------------- memory responder / stepping ----------------
    bit mem_busy = 0;
    int wait_cnt = 0;
    int lat_fix  = 0;   // <0 selects a random 0..3 wait per request

    task automatic step();
        @(posedge clk); #1;
        redirect = 1'b0;
        if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1;
                wait_cnt = (lat_fix < 0) ? int'($urandom_range(0, 3)) : lat_fix;
            end
            if (wait_cnt == 0) begin
                imem_ack = 1'b1; imem_rdata = imem_addr ^ 16'hA5A5; mem_busy = 0;
            end else begin
                imem_ack = 1'b0; wait_cnt--;
            end
        end else begin
            imem_ack = 1'b0; mem_busy = 0;
        end
    endtask

    task automatic do_reset(input int lat, input logic rdy, input logic hlt);
        rst = 1'b0; lat_fix = lat; inst_ready = rdy; halt = hlt;
        step(); step();
        rst = 1'b1;
    endtask

    task automatic wait_req(input logic [15:0] a, input string nm);
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if (imem_req && imem_addr == a) ok = 1;
        end
        chk(nm, ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // 1: reset values, then 0-wait back-to-back fetch
        rst = 1'b0; lat_fix = 0; inst_ready = 1'b1; halt = 1'b0;
        step(); step();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 16'h0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 16'h0);
        chk("rst_npc", inst_npc, 16'h0);
        chk("rst_err", err, 0);
        rst = 1'b1;
        step(); chk("t1_a0", imem_addr, 16'h0); chk("t1_req0", imem_req, 1);
        step(); chk("t1_a2", imem_addr, 16'h2);
        chk("t1_pc", inst_pc, 16'h0); chk("t1_inst", inst, 16'hA5A5); chk("t1_npc", inst_npc, 16'h2);
        step(); chk("t1_a4", imem_addr, 16'h4); chk("t1_pc2", inst_pc, 16'h2);
        step(); chk("t1_a6", imem_addr, 16'h6);

        // 2: consumer stalled, queue fills to DEPTH then issue stops
        do_reset(0, 1'b0, 1'b0);
        n = 0;
        repeat (8) begin step(); if (imem_req && imem_ack) n++; end
        chk("t2_nreq", n, 4);
        chk("t2_idle", imem_req, 0);
        chk("t2_head", inst_pc, 16'h0);
        chk("t2_model_cnt", q_pc.size(), 4);
        inst_ready = 1'b1;
        step(); chk("t2_pop_pc", inst_pc, 16'h2); chk("t2_req8", imem_req, 1); chk("t2_a8", imem_addr, 16'h8);
        repeat (4) step();

        // 3: redirect while a slow request is outstanding -> drain
        do_reset(3, 1'b1, 1'b0);
        wait_req(16'h4, "t3_wait4");
        step(); redirect = 1'b1; redirect_pc = 16'h0100;
        step(); chk("t3_flush", inst_valid, 0); chk("t3_drain_req", imem_req, 1); chk("t3_drain_a", imem_addr, 16'h4);
        for (int i = 0; i < 20 && !(imem_req && imem_addr != 16'h4); i++) step();
        chk("t3_new_a", imem_addr, 16'h0100);
        for (int i = 0; i < 20 && !inst_valid; i++) step();
        chk("t3_pc", inst_pc, 16'h0100); chk("t3_inst", inst, 16'hA4A5);

        // 4: redirect coincident with ack -> no drain
        do_reset(0, 1'b1, 1'b0);
        wait_req(16'h4, "t4_wait4");
        redirect = 1'b1; redirect_pc = 16'h0040;
        step(); chk("t4_idle", imem_req, 0); chk("t4_flush", inst_valid, 0);
        step(); chk("t4_req", imem_req, 1); chk("t4_a40", imem_addr, 16'h0040);

        // 5: halt with a request in flight, redirect under halt
        do_reset(2, 1'b0, 1'b0);
        wait_req(16'h0, "t5_wait0");
        halt = 1'b1;
        repeat (6) step();
        chk("t5_noreq", imem_req, 0); chk("t5_valid", inst_valid, 1); chk("t5_inst", inst, 16'hA5A5);
        step(); redirect = 1'b1; redirect_pc = 16'h0020;
        step(); chk("t5_flush", inst_valid, 0); chk("t5_halt_req", imem_req, 0);
        step(); chk("t5_halt_req2", imem_req, 0);
        halt = 1'b0;
        step(); chk("t5_req", imem_req, 1); chk("t5_a20", imem_addr, 16'h0020);

        // 6: ack in IDLE is sticky err; PC wrap at top of address space
        do_reset(0, 1'b1, 1'b1);
        step(); imem_ack = 1'b1;
        step(); chk("t6_err", err, 1);
        repeat (3) step();
        chk("t6_err_hold", err, 1);
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        step(); halt = 1'b0;
        step(); chk("t6_aFFFE", imem_addr, 16'hFFFE);
        step(); chk("t6_wrap", imem_addr, 16'h0000);
        chk("t6_pc", inst_pc, 16'hFFFE); chk("t6_npc", inst_npc, 16'h0000); chk("t6_inst", inst, 16'h5A5B);
        step(); rst = 1'b0; #1;
        chk("t6_async_err", err, 0); chk("t6_async_req", imem_req, 0);

        // random run
        do_reset(-1, 1'b1, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            step();
            inst_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 24) == 0) begin
                redirect = 1'b1;
                redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFA : 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE;
            end
            if ($urandom_range(0, 19) == 0) halt = ~halt;
        end
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
